lut_logic_filter: RTL



---
 rtl/lut_logic_filter.sv | 98 +++++++++
 1 files changed

// File: rtl/lut_logic_filter.sv
// Run-time loadable N_IN-input truth table with a registered pipeline and a
// stability filter on the output, plus a saturating count of rejected glitches.
module lut_logic_filter #(
  parameter int                   N_IN        = 5,
  parameter int                   FILTER      = 2,
  parameter int                   GCNT_W      = 8,
  parameter logic [2**N_IN-1:0]   DEFAULT_LUT = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_IN-1:0]      in_vec,
  input  logic                 cfg_valid,
  input  logic [2**N_IN-1:0]   cfg_data,
  output logic                 cfg_ready,
  input  logic                 glitch_clr,
  output logic                 y,
  output logic                 y_valid,
  output logic [GCNT_W-1:0]    glitch_cnt
);

  localparam int                LUT_W    = 2**N_IN;
  localparam int                SW       = (FILTER > 1) ? $clog2(FILTER) : 1;
  localparam logic [SW-1:0]     STAB_MAX = SW'(FILTER - 1);
  localparam logic [GCNT_W-1:0] GCNT_MAX = '1;

  typedef enum logic {FILL, RUN} mode_t;

  mode_t             mode;
  logic [LUT_W-1:0]  lut;
  logic [N_IN-1:0]   in_q;
  logic              raw_q;
  logic [1:0]        fill_cnt;
  logic [SW-1:0]     stab_cnt;
  logic              cfg_xfer;
  logic              glitch_evt;

  // Mode is derived from the fill counter; both handshake outputs follow it.
  always_comb begin
    mode       = FILL;
    if (fill_cnt == 2'd0) mode = RUN;
    cfg_ready  = (mode == RUN);
    y_valid    = (mode == RUN);
    cfg_xfer   = cfg_valid && cfg_ready;
    glitch_evt = (mode == RUN) && !cfg_xfer && (raw_q == y) && (stab_cnt != '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_q  <= '0;
      raw_q <= 1'b0;
    end else begin
      in_q  <= in_vec;
      raw_q <= lut[in_q];
    end
  end

  // A new table restarts the two-cycle fill so y_valid only covers results
  // computed from the current table.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lut      <= DEFAULT_LUT;
      fill_cnt <= 2'd2;
    end else if (cfg_xfer) begin
      lut      <= cfg_data;
      fill_cnt <= 2'd2;
    end else if (fill_cnt != 2'd0) begin
      fill_cnt <= fill_cnt - 2'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y        <= 1'b0;
      stab_cnt <= '0;
    end else if (mode == FILL || cfg_xfer) begin
      stab_cnt <= '0;
    end else if (raw_q == y) begin
      stab_cnt <= '0;
    end else if (stab_cnt == STAB_MAX) begin
      y        <= raw_q;
      stab_cnt <= '0;
    end else begin
      stab_cnt <= stab_cnt + 1'b1;
    end
  end

  // Clear wins over a same-cycle glitch event.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      glitch_cnt <= '0;
    end else if (glitch_clr) begin
      glitch_cnt <= '0;
    end else if (glitch_evt && glitch_cnt != GCNT_MAX) begin
      glitch_cnt <= glitch_cnt + 1'b1;
    end
  end

endmodule
